rr_burst_arbiter: RTL and testbench

Round-robin arbiter that shares one multi-beat resource, such as a cache or memory port, among NUM_REQUESTERS strands or units. It registers a one-hot grant and its binary index, and holds the grant for a burst of accepted beats. It releases on last beat, burst limit or request withdrawal, and can re-arbitrate back-to-back with no idle cycle. It sits between requesting units and the shared datapath, which consumes grant_idx as its mux select.

---
 rtl/rr_burst_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rr_burst_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
//   Round-robin arbiter sharing one multi-beat resource among NUM_REQUESTERS
//   units. The one-hot grant and its binary index are registered and held for
//   a burst of accepted beats. The grant is released on the last beat, at the
//   burst limit, or when the owner withdraws its request. Re-arbitration happens
//   on the releasing edge, so a new owner follows with no idle cycle.
//
//   Optional build macro: ARB_LOCK_EN adds the lock input. While lock is high
//   the burst limit does not release the grant.
//
// Ports
//   clk          clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   request      per-requester request level
//   grant_last   owner marks the current beat as its final beat
//   grant_ack    resource accepted a beat from the current owner
//   lock         (ARB_LOCK_EN only) owner extends its burst past MAX_BURST
//   grant_valid  a grant is active
//   grant_oh     one-hot owner, zero when idle
//   grant_idx    binary index of grant_oh, zero when idle
//   burst_end    combinational, the release condition is met this cycle
module rr_burst_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS),
  parameter int MAX_BURST      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      grant_last,
  input  logic                      grant_ack,
`ifdef ARB_LOCK_EN
  input  logic                      lock,
`endif
  output logic                      grant_valid,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic [INDEX_WIDTH-1:0]    grant_idx,
  output logic                      burst_end
);

  localparam int          CW = $clog2(MAX_BURST + 1);
  localparam int unsigned NR = NUM_REQUESTERS;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t                    state, state_n;
  logic [NUM_REQUESTERS-1:0] oh_n;
  logic [INDEX_WIDTH-1:0]    idx_n;
  logic [CW-1:0]             count, count_n;
  logic [INDEX_WIDTH-1:0]    ptr, ptr_n;

  logic                      owner_req;
  logic                      at_limit;
  logic                      rel_last, rel_limit, rel_drop;
  logic [INDEX_WIDTH-1:0]    arb_ptr;
  logic [NUM_REQUESTERS-1:0] arb_req;
  logic                      win_found;
  logic [INDEX_WIDTH-1:0]    win_idx;
  logic [NUM_REQUESTERS-1:0] win_oh;

  assign grant_valid = (state == GRANTED);

  // Release conditions
  assign owner_req = |(request & grant_oh);
  assign at_limit  = (count == CW'(MAX_BURST - 1));
  assign rel_last  = grant_ack & grant_last;
`ifdef ARB_LOCK_EN
  assign rel_limit = grant_ack & at_limit & ~lock;
`else
  assign rel_limit = grant_ack & at_limit;
`endif
  assign rel_drop  = ~owner_req;
  assign burst_end = grant_valid & (rel_last | rel_limit | rel_drop);

  // Arbitration: when granted, the releasing owner becomes the pointer, which
  // puts it last in scan order so it only wins again if nobody else asks.
  // A withdrawing owner is masked out entirely.
  assign arb_ptr = grant_valid ? grant_idx : ptr;
  assign arb_req = (grant_valid && rel_drop) ? (request & ~grant_oh) : request;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      if (!win_found &&
          arb_req[INDEX_WIDTH'((32'(arb_ptr) + k) % NR)]) begin
        win_found = 1'b1;
        win_idx   = INDEX_WIDTH'((32'(arb_ptr) + k) % NR);
      end
    end
  end

  assign win_oh = win_found ? (NUM_REQUESTERS'(1) << win_idx) : '0;

  // Next-state logic
  always_comb begin
    state_n = state;
    oh_n    = grant_oh;
    idx_n   = grant_idx;
    count_n = count;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = GRANTED;
          oh_n    = win_oh;
          idx_n   = win_idx;
          count_n = '0;
        end
      end
      GRANTED: begin
        if (burst_end) begin
          ptr_n   = grant_idx;
          count_n = '0;
          if (win_found) begin
            oh_n  = win_oh;
            idx_n = win_idx;
          end else begin
            state_n = IDLE;
            oh_n    = '0;
            idx_n   = '0;
          end
        end else if (grant_ack && !at_limit) begin
          // at_limit without release only happens under lock: saturate
          count_n = count + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        oh_n    = '0;
        idx_n   = '0;
        count_n = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_oh  <= '0;
      grant_idx <= '0;
      count     <= '0;
      ptr       <= INDEX_WIDTH'(NUM_REQUESTERS - 1);
    end else begin
      state     <= state_n;
      grant_oh  <= oh_n;
      grant_idx <= idx_n;
      count     <= count_n;
      ptr       <= ptr_n;
    end
  end

  // Structural invariants
  a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant_oh));
  a_valid_oh: assert property (@(posedge clk) disable iff (!reset_n)
    grant_valid == (|grant_oh));
  a_idx_match: assert property (@(posedge clk) disable iff (!reset_n)
    grant_valid |-> grant_oh[grant_idx]);
  a_idle_idx: assert property (@(posedge clk) disable iff (!reset_n)
    !grant_valid |-> (grant_idx == '0));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
module tb_rr_burst_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] request;
  logic       grant_last;
  logic       grant_ack;
  logic       lock;
  logic       grant_valid;
  logic [3:0] grant_oh;
  logic [1:0] grant_idx;
  logic       burst_end;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_burst_arbiter #(
    .NUM_REQUESTERS(4),
    .INDEX_WIDTH(2),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .request(request),
    .grant_last(grant_last),
    .grant_ack(grant_ack),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant_valid(grant_valid),
    .grant_oh(grant_oh),
    .grant_idx(grant_idx),
    .burst_end(burst_end)
  );

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       last;
    logic       e_end;
    logic       e_valid;
    logic [1:0] e_idx;
  } vec_t;

  typedef struct {
    logic       e_end;
    logic       e_valid;
    logic [1:0] e_idx;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[24];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare burst_end
  // seen before the edge and the registered grant seen after it.
  task automatic step(input logic [3:0] r, input logic a, input logic l, input logic lk,
                      input logic e_end, input logic e_valid, input logic [1:0] e_idx,
                      input string nm);
    exp_t e;
    logic end_seen;
    logic [3:0] e_oh;
    request    = r;
    grant_ack  = a;
    grant_last = l;
    lock       = lk;
    e.e_end = e_end; e.e_valid = e_valid; e.e_idx = e_idx; e.name = nm;
    sb.push_back(e);
    #1 end_seen = burst_end;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    e_oh = e.e_valid ? (4'b0001 << e.e_idx) : 4'b0000;
    check({e.name, "/burst_end"}, 32'(end_seen), 32'(e.e_end));
    check({e.name, "/grant_valid"}, 32'(grant_valid), 32'(e.e_valid));
    check({e.name, "/grant_oh"}, 32'(grant_oh), 32'(e_oh));
    check({e.name, "/grant_idx"}, 32'(grant_idx), 32'(e.e_idx));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        req      ack   last  end   valid idx
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // idle
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}; // first grant -> 0
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1}; // rotation
    tbl[5]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2};
    tbl[6]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3};
    tbl[7]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0};
    tbl[8]  = '{4'b1100, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2}; // owner 0 drops
    tbl[9]  = '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2}; // beat 1
    tbl[10] = '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2}; // beat 2
    tbl[11] = '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2}; // beat 3
    tbl[12] = '{4'b1100, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3}; // beat 4 limit
    tbl[13] = '{4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1}; // owner 3 drops
    tbl[14] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1}; // hold, no ack
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}; // withdraw -> idle
    tbl[16] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1}; // regrant 1
    tbl[17] = '{4'b0011, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0}; // last -> 0
    tbl[18] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0}; // last w/o ack
    tbl[19] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0}; // drop with ack
    tbl[20] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}; // ack while idle
    tbl[21] = '{4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3}; // ptr 0 -> 3
    tbl[22] = '{4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3}; // others ignored
    tbl[23] = '{4'b1110, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3}; // beat 1 of owner 3

    reset_n    = 1'b0;
    request    = '0;
    grant_ack  = 1'b0;
    grant_last = 1'b0;
    lock       = 1'b0;
    @(negedge clk);
    check("reset/grant_valid", 32'(grant_valid), 32'd0);
    check("reset/grant_oh", 32'(grant_oh), 32'd0);
    check("reset/grant_idx", 32'(grant_idx), 32'd0);
    check("reset/burst_end", 32'(burst_end), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].req, tbl[i].ack, tbl[i].last, 1'b0,
           tbl[i].e_end, tbl[i].e_valid, tbl[i].e_idx, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of owner 3's burst
    #2 reset_n = 1'b0;
    #1;
    check("async_rst/grant_valid", 32'(grant_valid), 32'd0);
    check("async_rst/grant_oh", 32'(grant_oh), 32'd0);
    check("async_rst/grant_idx", 32'(grant_idx), 32'd0);
    check("async_rst/burst_end", 32'(burst_end), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "post_rst");

    // Eight beats from a single requester with lock held, last on beat 8
    for (int b = 0; b < 8; b++) begin
      logic e_end;
`ifdef ARB_LOCK_EN
      e_end = (b == 7);
`else
      e_end = (b == 3) || (b == 7);
`endif
      step(4'b0001, 1'b1, (b == 7), 1'b1, e_end, 1'b1, 2'd0, $sformatf("burst_b%0d", b));
    end
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "burst_drop");

`ifdef ARB_LOCK_EN
    // Lock dropped while saturated releases on the next beat
    step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, "lock_grant");
    for (int b = 0; b < 5; b++)
      step(4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, $sformatf("lock_b%0d", b));
    step(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, "lock_drop");
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
